// File: rtl/jtobj_scan.sv
// Object table scanner: walks the 4-word object table for one video line and
// issues one draw request per 16-pixel tile of every object crossing that line.
module jtobj_scan #(
  parameter int         OBJW  = 8,
  parameter int         LIMIT = 0,
  parameter logic [9:0] YBIAS = 10'h10F
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            line_start,
  input  logic [8:0]      vline,
  input  logic            gfh,
  input  logic            gfv,
  input  logic [9:0]      xoff,
  input  logic [9:0]      yoff,
  output logic [OBJW+1:0] tbl_addr,
  input  logic [31:0]     tbl_data,
  output logic            dr_start,
  input  logic            dr_busy,
  output logic [15:0]     code,
  output logic [9:0]      attr,
  output logic [1:0]      shd,
  output logic            hflip,
  output logic            vflip,
  output logic [8:0]      hpos,
  output logic [3:0]      ysub,
  output logic [9:0]      hzoom,
  output logic            hz_keep,
  output logic            done,
  output logic            ovf
);

  typedef enum logic [2:0] {IDLE, F0, F1, F2, F3, CALC, DRAW, NEXT} state_t;

  typedef struct packed {
    logic        vf;
    logic        hf;
    logic [1:0]  vsz;
    logic [1:0]  hsz;
    logic [15:0] code;
    logic [9:0]  y;
    logic [9:0]  x;
    logic [9:0]  vzoom;
    logic [9:0]  hzoom;
    logic [1:0]  shd;
    logic [9:0]  attr;
  } obj_t;

  typedef struct packed {
    logic [15:0] vcode;
    logic [3:0]  ysub;
    logic        vflip;
    logic [8:0]  xpos;
  } calc_t;

  typedef struct packed {
    logic [15:0] code;
    logic [9:0]  attr;
    logic [1:0]  shd;
    logic        hflip;
    logic        vflip;
    logic [8:0]  hpos;
    logic [3:0]  ysub;
    logic [9:0]  hzoom;
    logic        hz_keep;
  } tile_t;

  state_t          state_q, state_d;
  obj_t            ob_q, ob_d;
  calc_t           ca_q, ca_d;
  tile_t           tile_q, tile_d;
  logic [OBJW-1:0] obj_q, obj_d;
  logic [15:0]     tcnt_q, tcnt_d;
  logic [8:0]      vline_q, vline_d;
  logic [2:0]      h_q, h_d;
  logic            dr_start_q, dr_start_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;

  logic [9:0]  y_fix, x_fix, yd;
  logic [18:0] prod;
  logic [12:0] row;
  logic [2:0]  vmask, hmask, vidx, hidx;
  logic        in_zone, vflip_c, hflip_c, limit_hit, can_issue, last_tile;
  logic [1:0]  tbl_word;

  // Tile indices add into interleaved 3-bit code fields; carries stay inside the field.
  function automatic logic [15:0] add_field(input logic [15:0] c, input logic [2:0] idx,
                                            input logic odd);
    logic [15:0] r;
    logic [2:0]  f;
    r = c;
    if (odd) begin
      f = {c[5], c[3], c[1]} + idx;
      {r[5], r[3], r[1]} = f;
    end else begin
      f = {c[4], c[2], c[0]} + idx;
      {r[4], r[2], r[0]} = f;
    end
    return r;
  endfunction

  always_comb begin
    y_fix     = (gfv ? -ob_q.y : ob_q.y) + yoff + YBIAS;
    x_fix     = (gfh ? -ob_q.x : ob_q.x) - xoff;
    yd        = {1'b0, vline_q} - y_fix;
    prod      = 19'(yd[8:0]) * 19'(ob_q.vzoom);
    row       = 13'(prod >> 6);
    in_zone   = !yd[9] && (row < (13'd16 << ob_q.vsz));
    vmask     = 3'((4'd1 << ob_q.vsz) - 4'd1);
    hmask     = 3'((4'd1 << ob_q.hsz) - 4'd1);
    vflip_c   = ob_q.vf ^ gfv;
    hflip_c   = ob_q.hf ^ gfh;
    vidx      = (row[6:4] & vmask) ^ (vflip_c ? vmask : 3'd0);
    hidx      = hflip_c ? (hmask - h_q) : h_q;
    limit_hit = (LIMIT > 0) && (tcnt_q == 16'(LIMIT));
    can_issue = !dr_busy && !dr_start_q;
    last_tile = (h_q == hmask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state_q <= IDLE;
    else if (cen) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (line_start) state_d = F0;
    else begin
      case (state_q)
        F0:      state_d = tbl_data[31] ? F1 : NEXT;
        F1:      state_d = F2;
        F2:      state_d = F3;
        F3:      state_d = CALC;
        CALC:    state_d = (in_zone && !x_fix[9]) ? DRAW : NEXT;
        DRAW:    if (limit_hit) state_d = IDLE;
                 else if (can_issue && last_tile) state_d = NEXT;
        NEXT:    state_d = (&obj_q) ? IDLE : F0;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    ob_d       = ob_q;
    ca_d       = ca_q;
    tile_d     = tile_q;
    obj_d      = obj_q;
    tcnt_d     = tcnt_q;
    vline_d    = vline_q;
    h_d        = h_q;
    dr_start_d = 1'b0;
    done_d     = done_q;
    ovf_d      = ovf_q;
    if (line_start) begin
      obj_d   = '0;
      tcnt_d  = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      vline_d = vline;
    end else begin
      case (state_q)
        F0: begin
          ob_d.vf   = tbl_data[30];
          ob_d.hf   = tbl_data[29];
          ob_d.vsz  = tbl_data[28:27];
          ob_d.hsz  = tbl_data[26:25];
          ob_d.code = tbl_data[15:0];
        end
        F1: begin
          ob_d.y = tbl_data[25:16];
          ob_d.x = tbl_data[9:0];
        end
        F2: begin
          ob_d.vzoom = tbl_data[25:16];
          ob_d.hzoom = tbl_data[9:0];
        end
        F3: begin
          ob_d.shd  = tbl_data[11:10];
          ob_d.attr = tbl_data[9:0];
        end
        CALC: begin
          ca_d.vcode = add_field(ob_q.code, vidx, 1'b1);
          ca_d.ysub  = row[3:0];
          ca_d.vflip = vflip_c;
          ca_d.xpos  = x_fix[8:0];
          h_d        = '0;
        end
        DRAW: begin
          if (limit_hit) begin
            ovf_d  = 1'b1;
            done_d = 1'b1;
          end else if (can_issue) begin
            dr_start_d     = 1'b1;
            tcnt_d         = tcnt_q + 16'd1;
            h_d            = h_q + 3'd1;
            tile_d.code    = add_field(ca_q.vcode, hidx, 1'b0);
            tile_d.attr    = ob_q.attr;
            tile_d.shd     = ob_q.shd;
            tile_d.hflip   = hflip_c;
            tile_d.vflip   = ca_q.vflip;
            tile_d.hpos    = ca_q.xpos + {2'b00, h_q, 4'b0000};
            tile_d.ysub    = ca_q.ysub;
            tile_d.hzoom   = ob_q.hzoom;
            tile_d.hz_keep = (h_q != 3'd0);
          end
        end
        NEXT: begin
          obj_d = obj_q + 1'b1;
          if (&obj_q) done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ob_q       <= '0;
      ca_q       <= '0;
      tile_q     <= '0;
      obj_q      <= '0;
      tcnt_q     <= '0;
      vline_q    <= '0;
      h_q        <= '0;
      dr_start_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (cen) begin
      ob_q       <= ob_d;
      ca_q       <= ca_d;
      tile_q     <= tile_d;
      obj_q      <= obj_d;
      tcnt_q     <= tcnt_d;
      vline_q    <= vline_d;
      h_q        <= h_d;
      dr_start_q <= dr_start_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    case (state_q)
      F1:      tbl_word = 2'd1;
      F2:      tbl_word = 2'd2;
      F3:      tbl_word = 2'd3;
      default: tbl_word = 2'd0;
    endcase
    tbl_addr = {obj_q, tbl_word};
  end

  assign dr_start = dr_start_q;
  assign code     = tile_q.code;
  assign attr     = tile_q.attr;
  assign shd      = tile_q.shd;
  assign hflip    = tile_q.hflip;
  assign vflip    = tile_q.vflip;
  assign hpos     = tile_q.hpos;
  assign ysub     = tile_q.ysub;
  assign hzoom    = tile_q.hzoom;
  assign hz_keep  = tile_q.hz_keep;
  assign done     = done_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_jtobj_scan.sv
// Scoreboard bench for jtobj_scan: an unlimited 256-object instance and a
// 4-object instance with a 2-tile line limit, both fed from bench-side tables.
module tb_jtobj_scan;

  typedef struct packed {
    logic [15:0] code;
    logic [9:0]  attr;
    logic [1:0]  shd;
    logic        hflip;
    logic        vflip;
    logic [8:0]  hpos;
    logic [3:0]  ysub;
    logic [9:0]  hzoom;
    logic        hz_keep;
  } tile_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic       line_start_a = 1'b0;
  logic       line_start_b = 1'b0;
  logic [8:0] vline = '0;
  logic       gfh = 1'b0;
  logic       gfv = 1'b0;
  logic [9:0] xoff = '0;
  logic [9:0] yoff = '0;
  logic       dr_busy = 1'b0;

  logic [9:0]  a_tbl_addr;
  logic [31:0] a_tbl_data;
  logic        a_dr_start, a_hflip, a_vflip, a_hz_keep, a_done, a_ovf;
  logic [15:0] a_code;
  logic [9:0]  a_attr, a_hzoom;
  logic [1:0]  a_shd;
  logic [8:0]  a_hpos;
  logic [3:0]  a_ysub;

  logic [3:0]  b_tbl_addr;
  logic [31:0] b_tbl_data;
  logic        b_dr_start, b_hflip, b_vflip, b_hz_keep, b_done, b_ovf;
  logic [15:0] b_code;
  logic [9:0]  b_attr, b_hzoom;
  logic [1:0]  b_shd;
  logic [8:0]  b_hpos;
  logic [3:0]  b_ysub;

  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:15];
  tile_t       q_a[$];
  tile_t       q_b[$];
  tile_t       act_a, act_b, exp_a, exp_b;
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc;

  assign a_tbl_data = mem_a[a_tbl_addr];
  assign b_tbl_data = mem_b[b_tbl_addr];

  always #5 clk = ~clk;

  jtobj_scan dut_a (
    .clk(clk), .rst(rst), .cen(cen), .line_start(line_start_a), .vline(vline),
    .gfh(gfh), .gfv(gfv), .xoff(xoff), .yoff(yoff),
    .tbl_addr(a_tbl_addr), .tbl_data(a_tbl_data), .dr_start(a_dr_start), .dr_busy(dr_busy),
    .code(a_code), .attr(a_attr), .shd(a_shd), .hflip(a_hflip), .vflip(a_vflip),
    .hpos(a_hpos), .ysub(a_ysub), .hzoom(a_hzoom), .hz_keep(a_hz_keep),
    .done(a_done), .ovf(a_ovf)
  );

  jtobj_scan #(.OBJW(2), .LIMIT(2)) dut_b (
    .clk(clk), .rst(rst), .cen(cen), .line_start(line_start_b), .vline(vline),
    .gfh(gfh), .gfv(gfv), .xoff(xoff), .yoff(yoff),
    .tbl_addr(b_tbl_addr), .tbl_data(b_tbl_data), .dr_start(b_dr_start), .dr_busy(dr_busy),
    .code(b_code), .attr(b_attr), .shd(b_shd), .hflip(b_hflip), .vflip(b_vflip),
    .hpos(b_hpos), .ysub(b_ysub), .hzoom(b_hzoom), .hz_keep(b_hz_keep),
    .done(b_done), .ovf(b_ovf)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Every dr_start pulse is matched against the oldest expected tile.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_dr_start) begin
        act_a = {a_code, a_attr, a_shd, a_hflip, a_vflip, a_hpos, a_ysub, a_hzoom, a_hz_keep};
        if (q_a.size() == 0) checkOutput("tile_a_unexpected", 64'(act_a), 64'd0);
        else begin
          exp_a = q_a.pop_front();
          checkOutput("tile_a", 64'(act_a), 64'(exp_a));
        end
      end
      if (b_dr_start) begin
        act_b = {b_code, b_attr, b_shd, b_hflip, b_vflip, b_hpos, b_ysub, b_hzoom, b_hz_keep};
        if (q_b.size() == 0) checkOutput("tile_b_unexpected", 64'(act_b), 64'd0);
        else begin
          exp_b = q_b.pop_front();
          checkOutput("tile_b", 64'(act_b), 64'(exp_b));
        end
      end
    end
  end

  task automatic exp_tile(input bit b, input logic [15:0] c, input logic [9:0] at,
                          input logic [1:0] sh, input logic hf, input logic vf,
                          input logic [8:0] hp, input logic [3:0] ys,
                          input logic [9:0] hz, input logic hk);
    tile_t t;
    t = {c, at, sh, hf, vf, hp, ys, hz, hk};
    if (b) q_b.push_back(t);
    else   q_a.push_back(t);
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 1024; i++) mem_a[i] = '0;
    for (int i = 0; i < 16; i++) mem_b[i] = '0;
  endtask

  task automatic set_obj(input bit b, input int idx, input logic [31:0] w0,
                         input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
    if (b) begin
      mem_b[idx*4] = w0; mem_b[idx*4+1] = w1; mem_b[idx*4+2] = w2; mem_b[idx*4+3] = w3;
    end else begin
      mem_a[idx*4] = w0; mem_a[idx*4+1] = w1; mem_a[idx*4+2] = w2; mem_a[idx*4+3] = w3;
    end
  endtask

  // Starts a scan, waits (bounded) for done, then checks status and leftovers.
  task automatic applyStimulus(input bit b, input logic [8:0] vl, input logic exp_ovf,
                               input string name, output int cycles);
    vline = vl;
    @(negedge clk);
    if (b) line_start_b = 1'b1;
    else   line_start_a = 1'b1;
    @(negedge clk);
    line_start_a = 1'b0;
    line_start_b = 1'b0;
    checkOutput({name, "_done_clear"}, 64'(b ? b_done : a_done), 64'd0);
    cycles = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (b ? b_done : a_done) begin
        cycles = i;
        break;
      end
    end
    checkOutput({name, "_done"}, 64'(b ? b_done : a_done), 64'd1);
    checkOutput({name, "_ovf"}, 64'(b ? b_ovf : a_ovf), 64'(exp_ovf));
    repeat (3) @(negedge clk);
    checkOutput({name, "_missing_tiles"}, 64'(b ? q_b.size() : q_a.size()), 64'd0);
    q_a.delete();
    q_b.delete();
  endtask

  initial begin
    clear_tables();
    repeat (3) @(negedge clk);
    checkOutput("reset_tile_a",
                64'({a_code, a_attr, a_shd, a_hflip, a_vflip, a_hpos, a_ysub, a_hzoom, a_hz_keep}),
                64'd0);
    checkOutput("reset_status_a", 64'({a_tbl_addr, a_dr_start, a_done, a_ovf}), 64'd0);
    checkOutput("reset_status_b", 64'({b_tbl_addr, b_dr_start, b_done, b_ovf, b_code}), 64'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("done_after_reset", 64'(a_done), 64'd0);

    // All entries disabled: one F0/NEXT pair per object, nothing drawn.
    applyStimulus(0, 9'd0, 1'b0, "all_disabled", cyc);
    checkOutput("all_disabled_cycles", 64'(cyc), 64'd512);

    // Single 1:1 object, five lines into it, placed mid-table.
    clear_tables();
    set_obj(0, 200, 32'h8000_0000, 32'h0000_0000, 32'h0040_0040, 32'h0000_07FF);
    exp_tile(0, 16'h0000, 10'h3FF, 2'd1, 1'b0, 1'b0, 9'h000, 4'h5, 10'h040, 1'b0);
    applyStimulus(0, 9'd276, 1'b0, "single", cyc);

    // Four-wide flipped object.
    clear_tables();
    set_obj(0, 0, 32'hA400_0000, 32'h0000_0020, 32'h0040_0155, 32'h0000_0012);
    exp_tile(0, 16'h0005, 10'h012, 2'd0, 1'b1, 1'b0, 9'h020, 4'h5, 10'h155, 1'b0);
    exp_tile(0, 16'h0004, 10'h012, 2'd0, 1'b1, 1'b0, 9'h030, 4'h5, 10'h155, 1'b1);
    exp_tile(0, 16'h0001, 10'h012, 2'd0, 1'b1, 1'b0, 9'h040, 4'h5, 10'h155, 1'b1);
    exp_tile(0, 16'h0000, 10'h012, 2'd0, 1'b1, 1'b0, 9'h050, 4'h5, 10'h155, 1'b1);
    applyStimulus(0, 9'd276, 1'b0, "hflip4", cyc);

    // Half-zoom row and field carry wrap with offsets applied.
    clear_tables();
    yoff = 10'd5;
    xoff = 10'h010;
    set_obj(0, 3, 32'h8000_0000, 32'h0000_0050, 32'h0020_0040, 32'h0000_0155);
    set_obj(0, 7, 32'h8A00_F0BF, 32'h0000_0050, 32'h0040_0040, 32'h0000_0801);
    exp_tile(0, 16'h0000, 10'h155, 2'd0, 1'b0, 1'b0, 9'h040, 4'hA, 10'h040, 1'b0);
    exp_tile(0, 16'hF095, 10'h001, 2'd2, 1'b0, 1'b0, 9'h040, 4'h4, 10'h040, 1'b0);
    exp_tile(0, 16'hF080, 10'h001, 2'd2, 1'b0, 1'b0, 9'h050, 4'h4, 10'h040, 1'b1);
    applyStimulus(0, 9'd296, 1'b0, "zoom_carry", cyc);
    yoff = '0;
    xoff = '0;

    // Zone boundaries: double zoom, X[9], negative distance, row 15 and row 16.
    clear_tables();
    set_obj(0, 0, 32'h8000_0001, 32'h0000_0000, 32'h0080_0040, 32'h0000_0000);
    set_obj(0, 1, 32'h8000_0002, 32'h0000_0200, 32'h0040_0040, 32'h0000_0000);
    set_obj(0, 2, 32'h8000_0003, 32'h0014_0000, 32'h0040_0040, 32'h0000_0000);
    set_obj(0, 9, 32'h8000_0777, 32'h0000_0000, 32'h0040_0040, 32'h0000_03AA);
    set_obj(0, 10, 32'h8000_0001, 32'h0000_0000, 32'h0060_0040, 32'h0000_0000);
    set_obj(0, 11, 32'h8000_0004, 32'h0000_0000, 32'h0067_0040, 32'h0000_0000);
    exp_tile(0, 16'h0777, 10'h3AA, 2'd0, 1'b0, 1'b0, 9'h000, 4'hA, 10'h040, 1'b0);
    exp_tile(0, 16'h0001, 10'h000, 2'd0, 1'b0, 1'b0, 9'h000, 4'hF, 10'h040, 1'b0);
    applyStimulus(0, 9'd281, 1'b0, "zone", cyc);

    // Global flips negate both coordinates and flip the vertical tile index.
    clear_tables();
    gfv = 1'b1;
    gfh = 1'b1;
    set_obj(0, 0, 32'h8800_0000, 32'h03F0_03E0, 32'h0040_0040, 32'h0000_0000);
    exp_tile(0, 16'h0002, 10'h000, 2'd0, 1'b1, 1'b1, 9'h020, 4'h3, 10'h040, 1'b0);
    applyStimulus(0, 9'd290, 1'b0, "global_flip", cyc);
    gfv = 1'b0;
    gfh = 1'b0;

    // Restart while the drawer stalls DRAW: only the new table contents are drawn.
    clear_tables();
    set_obj(0, 0, 32'h8400_0100, 32'h0000_0000, 32'h0040_0040, 32'h0000_07FF);
    dr_busy = 1'b1;
    vline = 9'd276;
    @(negedge clk);
    line_start_a = 1'b1;
    @(negedge clk);
    line_start_a = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("busy_stall_done", 64'(a_done), 64'd0);
    set_obj(0, 0, 32'h8000_1234, 32'h0000_0000, 32'h0040_0040, 32'h0000_07FF);
    exp_tile(0, 16'h1234, 10'h3FF, 2'd1, 1'b0, 1'b0, 9'h000, 4'h5, 10'h040, 1'b0);
    fork
      begin
        repeat (8) @(negedge clk);
        dr_busy = 1'b0;
      end
    join_none
    applyStimulus(0, 9'd276, 1'b0, "restart", cyc);

    // Per-line limit of two tiles with three candidates.
    clear_tables();
    set_obj(1, 0, 32'h8000_0001, 32'h0000_0000, 32'h0040_0040, 32'h0000_07FF);
    set_obj(1, 1, 32'h8000_0002, 32'h0000_0000, 32'h0040_0040, 32'h0000_07FF);
    set_obj(1, 2, 32'h8000_0003, 32'h0000_0000, 32'h0040_0040, 32'h0000_07FF);
    exp_tile(1, 16'h0001, 10'h3FF, 2'd1, 1'b0, 1'b0, 9'h000, 4'h5, 10'h040, 1'b0);
    exp_tile(1, 16'h0002, 10'h3FF, 2'd1, 1'b0, 1'b0, 9'h000, 4'h5, 10'h040, 1'b0);
    applyStimulus(1, 9'd276, 1'b1, "limit", cyc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
